// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable generator.
// Mode encodings are also consumed by the CPU control unit.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HALT = 2'b01,
    MODE_STEP = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  // Reset divisor; never below one cycle per tick.
  function automatic int unsigned calc_div(
    input int unsigned in_clk,
    input int unsigned out_clk
  );
    int unsigned d;
    d = (out_clk == 0) ? 1 : in_clk / out_clk;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for a raw push-button.
// o_rise pulses in the cycle the debounced level becomes 1.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 160_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned DB = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
  localparam int W = $clog2(DB + 1);
  localparam logic [W-1:0] LAST = W'(DB - 1);

  logic         sync1;
  logic         sync2;
  logic [W-1:0] db_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db_cnt  <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      sync1  <= i_raw;
      sync2  <= sync1;
      o_rise <= 1'b0;
      if (sync2 == o_level) begin
        db_cnt <= '0;
      end else if (db_cnt == LAST) begin
        db_cnt  <= '0;
        o_level <= sync2;
        o_rise  <= sync2;
      end else begin
        db_cnt <= db_cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: run/halt/step/fast modes, loadable
// divisor, debounced step button and a wrapping tick counter.
import cpu_clock_ctrl_pkg::*;

module cpu_clock_ctrl #(
  parameter int unsigned INPUT_CLOCK     = 16_000_000,
  parameter int unsigned OUTPUT_CLOCK    = 1,
  parameter int          CNT_WIDTH       = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 160_000,
  parameter int          TCNT_WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_mode,
  input  logic                  i_step_btn,
  input  logic                  i_div_load,
  input  logic [CNT_WIDTH-1:0]  i_div_value,
  output logic                  o_tick,
  output logic                  o_square,
  output logic [TCNT_WIDTH-1:0] o_tick_count,
  output logic                  o_halted
);

  localparam logic [CNT_WIDTH-1:0] DEFAULT_DIV =
    CNT_WIDTH'(calc_div(INPUT_CLOCK, OUTPUT_CLOCK));

  mode_e                state;
  logic [CNT_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0] div_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 tick_d;
  logic                 step_rise;
  logic                 step_level_unused;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_step_btn),
    .o_level(step_level_unused),
    .o_rise (step_rise)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= MODE_HALT;
    else       state <= mode_e'(i_mode);
  end

  // A divisor load restarts the period and swallows any tick due now.
  always_comb begin
    cnt_d  = cnt;
    div_d  = div_q;
    tick_d = 1'b0;
    if (i_div_load) begin
      div_d = (i_div_value == '0) ? CNT_WIDTH'(1) : i_div_value;
      cnt_d = '0;
    end else begin
      unique case (state)
        MODE_RUN: begin
          if (cnt == div_q - CNT_WIDTH'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_WIDTH'(1);
          end
        end
        MODE_HALT: cnt_d = cnt;
        MODE_STEP: begin
          cnt_d  = '0;
          tick_d = step_rise;
        end
        MODE_FAST: begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q        <= DEFAULT_DIV;
      cnt          <= '0;
      o_tick       <= 1'b0;
      o_square     <= 1'b0;
      o_tick_count <= '0;
    end else begin
      div_q  <= div_d;
      cnt    <= cnt_d;
      o_tick <= tick_d;
      if (tick_d) begin
        o_square     <= ~o_square;
        o_tick_count <= o_tick_count + TCNT_WIDTH'(1);
      end
    end
  end

  assign o_halted = (state == MODE_HALT) || (state == MODE_STEP);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed segment table, async reset
// sequence and randomized traffic against a behavioural model.
module tb_cpu_clock_ctrl;

  localparam int N = 4;
  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] HALT = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] FAST = 2'd3;

  typedef struct {
    logic [1:0] mode;
    bit         btn;
    bit         load;
    int         val;
    int         ncyc;
    int         exp_ticks;
    bit         exp_last;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = HALT;
  logic        btn = 1'b0;
  logic        load = 1'b0;
  logic [31:0] val = '0;
  logic        tick;
  logic        square;
  logic [15:0] tick_count;
  logic        halted;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // behavioural model state
  int m_state;
  int m_cnt;
  int m_div;
  int m_count;
  bit m_tick;
  bit m_sq;
  bit m_level;
  bit m_rise;
  bit hist[$];

  row_t rows[19];
  row_t rrows[4];

  cpu_clock_ctrl #(
    .INPUT_CLOCK    (8),
    .OUTPUT_CLOCK   (1),
    .CNT_WIDTH      (32),
    .DEBOUNCE_CYCLES(N),
    .TCNT_WIDTH     (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mode      (mode),
    .i_step_btn  (btn),
    .i_div_load  (load),
    .i_div_value (val),
    .o_tick      (tick),
    .o_square    (square),
    .o_tick_count(tick_count),
    .o_halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 1;
    m_cnt   = 0;
    m_div   = 8;
    m_count = 0;
    m_tick  = 0;
    m_sq    = 0;
    m_level = 0;
    m_rise  = 0;
    hist.delete();
    for (int j = 0; j <= N; j++) hist.push_back(1'b0);
  endtask

  // hist[j] holds the button sampled j+1 edges ago; the debounced
  // level flips once the N synchronised samples all disagree with it.
  task automatic model_edge();
    bit nt;
    bit all_diff;
    nt = 0;
    if (load) begin
      m_div = (val == 0) ? 1 : int'(val);
      m_cnt = 0;
    end else begin
      case (m_state)
        0: begin
          if (m_cnt + 1 >= m_div) begin
            nt = 1;
            m_cnt = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
        2: begin
          m_cnt = 0;
          nt = m_rise;
        end
        3: begin
          m_cnt = 0;
          nt = 1;
        end
        default: ;
      endcase
    end
    m_tick = nt;
    if (nt) begin
      m_sq = ~m_sq;
      m_count = (m_count + 1) % 65536;
    end
    all_diff = 1;
    for (int j = 1; j <= N; j++)
      if (hist[j] == m_level) all_diff = 0;
    m_rise = 0;
    if (all_diff) begin
      m_level = ~m_level;
      m_rise = m_level;
    end
    hist.push_front(btn);
    void'(hist.pop_back());
    m_state = int'(mode);
  endtask

  task automatic check_model();
    bit h;
    h = (m_state == 1) || (m_state == 2);
    tests++;
    if (tick !== m_tick || square !== m_sq ||
        tick_count !== 16'(m_count) || halted !== h) begin
      fails++;
      $display("FAIL model cyc=%0d tick=%0b/%0b sq=%0b/%0b cnt=%0d/%0d halted=%0b/%0b (got/want)",
               cyc, tick, m_tick, square, m_sq, tick_count, m_count, halted, h);
    end
  endtask

  task automatic check_reset(input string tag);
    tests++;
    if (tick !== 1'b0 || square !== 1'b0 ||
        tick_count !== 16'd0 || halted !== 1'b1) begin
      fails++;
      $display("FAIL %s tick=%0b sq=%0b cnt=%0d halted=%0b want 0/0/0/1",
               tag, tick, square, tick_count, halted);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_model();
  endtask

  task automatic run_row(input row_t r, input int idx);
    int seen;
    bit last;
    mode = r.mode;
    btn  = r.btn;
    load = r.load;
    val  = r.val;
    seen = 0;
    last = 0;
    for (int i = 0; i < r.ncyc; i++) begin
      cycle();
      if (tick === 1'b1) seen++;
      last = (tick === 1'b1);
    end
    load = 1'b0;
    tests++;
    if (seen != r.exp_ticks || last != r.exp_last) begin
      fails++;
      $display("FAIL row%0d ticks=%0d last=%0b want ticks=%0d last=%0b",
               idx, seen, last, r.exp_ticks, r.exp_last);
    end
  endtask

  initial begin
    rows[0]  = '{RUN,  0, 0, 0, 9, 1, 1};
    rows[1]  = '{RUN,  0, 0, 0, 8, 1, 1};
    rows[2]  = '{RUN,  0, 0, 0, 4, 0, 0};
    rows[3]  = '{HALT, 0, 0, 0, 20, 0, 0};
    rows[4]  = '{RUN,  0, 0, 0, 4, 1, 1};
    rows[5]  = '{RUN,  0, 0, 0, 7, 0, 0};
    rows[6]  = '{RUN,  0, 1, 3, 1, 0, 0};
    rows[7]  = '{RUN,  0, 0, 0, 3, 1, 1};
    rows[8]  = '{RUN,  0, 0, 0, 6, 2, 1};
    rows[9]  = '{RUN,  0, 1, 0, 1, 0, 0};
    rows[10] = '{RUN,  0, 0, 0, 5, 5, 1};
    rows[11] = '{FAST, 0, 0, 0, 70000, 70000, 1};
    rows[12] = '{STEP, 0, 0, 0, 10, 1, 0};
    rows[13] = '{STEP, 1, 0, 0, 10, 1, 0};
    rows[14] = '{STEP, 0, 0, 0, 10, 0, 0};
    rows[15] = '{STEP, 1, 0, 0, 2, 0, 0};
    rows[16] = '{STEP, 0, 0, 0, 10, 0, 0};
    rows[17] = '{HALT, 1, 0, 0, 10, 0, 0};
    rows[18] = '{STEP, 1, 0, 0, 10, 0, 0};
    rrows[0] = '{RUN,  0, 1, 8, 1, 0, 0};
    rrows[1] = '{RUN,  0, 0, 0, 4, 0, 0};
    rrows[2] = '{HALT, 0, 0, 0, 20, 0, 0};
    rrows[3] = '{RUN,  0, 0, 0, 9, 1, 1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset("reset_release");

    for (int i = 0; i < 19; i++) run_row(rows[i], i);

    tests++;
    if (tick_count !== 16'd4477 || square !== 1'b1) begin
      fails++;
      $display("FAIL wrap_total cnt=%0d sq=%0b want 4477/1",
               tick_count, square);
    end

    run_row(rrows[0], 100);
    run_row(rrows[1], 101);
    #2;
    rst  = 1'b1;
    mode = HALT;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset("reset_hold");
    run_row(rrows[2], 102);
    run_row(rrows[3], 103);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) btn = ~btn;
      load = ($urandom_range(49) == 0);
      val  = 32'($urandom_range(10));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
